// File: rtl/bf16_dot_seq.sv
// bf16_dot_seq: sequential bfloat16 dot-product issue stage.
// Drives one shared combinational fpu with two ops per element: MUL (a*b),
// then ADD (acc+product). The fpu result is captured in the same cycle it is
// produced. The finished sum, a sticky overflow flag and the element count
// are presented on the output handshake when the element tagged last completes.
module bf16_dot_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_a_i,
  input  logic [15:0]      in_b_i,
  input  logic             in_last_i,
  output logic [3:0]       fpu_op_o,
  output logic [15:0]      fpu_in1_o,
  output logic [15:0]      fpu_in2_o,
  input  logic [15:0]      fpu_out_i,
  input  logic             fpu_ovf_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [15:0]      out_data_o,
  output logic             out_ovf_o,
  output logic [CNT_W-1:0] out_cnt_o
);

  localparam logic [3:0] OP_IDLE = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [15:0]      a_q, b_q;
  logic             last_q;
  logic [15:0]      prod_q;
  logic [15:0]      acc_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  // A new pair can be taken from IDLE, or straight out of a non-final ADD so
  // back-to-back elements issue every two cycles.
  assign in_ready_o = (state_q == S_IDLE) || ((state_q == S_ADD) && !last_q);

  logic accept;
  assign accept = in_valid_i && in_ready_o;

  // Result port is only live in DONE; elsewhere it reads as zero.
  assign out_valid_o = (state_q == S_DONE);
  assign out_data_o  = (state_q == S_DONE) ? acc_q : 16'h0000;
  assign out_ovf_o   = (state_q == S_DONE) ? ovf_q : 1'b0;
  assign out_cnt_o   = (state_q == S_DONE) ? cnt_q : '0;

  // fpu op/operand decode, purely from registered state.
  always_comb begin
    fpu_op_o  = OP_IDLE;
    fpu_in1_o = 16'h0000;
    fpu_in2_o = 16'h0000;
    case (state_q)
      S_MUL: begin
        fpu_op_o  = OP_MUL;
        fpu_in1_o = a_q;
        fpu_in2_o = b_q;
      end
      S_ADD: begin
        fpu_op_o  = OP_ADD;
        fpu_in1_o = acc_q;
        fpu_in2_o = prod_q;
      end
      default: ;
    endcase
  end

  // Sequencer: operand capture, fpu result capture, accumulator and count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      prod_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q     <= in_a_i;
            b_q     <= in_b_i;
            last_q  <= in_last_i;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          prod_q  <= fpu_out_i;
          ovf_q   <= ovf_q | fpu_ovf_i;
          state_q <= S_ADD;
        end
        S_ADD: begin
          // Overflow never aborts; whatever the fpu returns is accumulated.
          acc_q <= fpu_out_i;
          ovf_q <= ovf_q | fpu_ovf_i;
          if (last_q) begin
            state_q <= S_DONE;
          end else if (accept) begin
            a_q     <= in_a_i;
            b_q     <= in_b_i;
            last_q  <= in_last_i;
            cnt_q   <= cnt_q + 1'b1;
            state_q <= S_MUL;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_DONE: begin
          // Clear vector state on handshake so the next vector starts at +0.
          if (out_ready_i) begin
            acc_q   <= 16'h0000;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_dot_seq.sv
// Testbench for bf16_dot_seq: a small fpu lookup model answers the DUT's
// fpu requests; directed vectors plus hand-written cycle sequences.
module tb_bf16_dot_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_a, in_b;
  logic [3:0]  fpu_op;
  logic [15:0] fpu_in1, fpu_in2, fpu_out;
  logic        fpu_ovf;
  logic        out_valid, out_ready, out_ovf;
  logic [15:0] out_data, out_cnt;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bf16_dot_seq #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .in_last_i(in_last),
    .fpu_op_o(fpu_op), .fpu_in1_o(fpu_in1), .fpu_in2_o(fpu_in2),
    .fpu_out_i(fpu_out), .fpu_ovf_i(fpu_ovf),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_ovf_o(out_ovf), .out_cnt_o(out_cnt)
  );

  // fpu model: exact bf16 results for the operands this bench uses.
  always_comb begin
    fpu_out = 16'h0000;
    fpu_ovf = 1'b0;
    if (fpu_op == 4'b0100) begin
      case ({fpu_in1, fpu_in2})
        {16'h3F80, 16'h4000}: fpu_out = 16'h4000; // 1*2
        {16'h4040, 16'h3F00}: fpu_out = 16'h3FC0; // 3*0.5
        {16'h3F80, 16'h3F80}: fpu_out = 16'h3F80; // 1*1
        {16'h4000, 16'h4000}: fpu_out = 16'h4080; // 2*2
        {16'h7F00, 16'h7F00}: begin fpu_out = 16'h7F80; fpu_ovf = 1'b1; end
        default:              fpu_out = 16'hDEAD;
      endcase
    end else if (fpu_op == 4'b0001) begin
      if (fpu_in1 == 16'h0000) fpu_out = fpu_in2;
      else case ({fpu_in1, fpu_in2})
        {16'h4000, 16'h3FC0}: fpu_out = 16'h4060; // 2+1.5
        {16'h7F80, 16'h3F80}: fpu_out = 16'h7F80; // inf+1
        default:              fpu_out = 16'hDEAD;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic [15:0] a0, b0, a1, b1;
    int          gap;
    int          bp;
    logic [15:0] ed;
    logic        eo;
    logic [15:0] ec;
  } vec_t;

  vec_t vecs[5];

  // Offer one pair and wait (bounded) until it is taken on the next edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1; @(negedge clk); break; end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    bit got;
    logic [15:0] d0;
    v = vecs[k];
    send(v.a0, v.b0, v.n == 1);
    if (v.n == 2) begin
      for (int j = 0; j < v.gap; j++) begin
        @(negedge clk);
        if (j >= 1) begin
          chk($sformatf("v%0d_gap_op", k), {28'd0, fpu_op}, 32'd0);
          chk($sformatf("v%0d_gap_rdy", k), {31'd0, in_ready}, 32'd1);
        end
      end
      send(v.a1, v.b1, 1'b1);
    end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin got = 1; break; end
      @(negedge clk);
    end
    chk($sformatf("v%0d_valid", k), {31'd0, got}, 32'd1);
    chk($sformatf("v%0d_data", k), {16'd0, out_data}, {16'd0, v.ed});
    chk($sformatf("v%0d_ovf", k), {31'd0, out_ovf}, {31'd0, v.eo});
    chk($sformatf("v%0d_cnt", k), {16'd0, out_cnt}, {16'd0, v.ec});
    d0 = out_data;
    for (int i = 0; i < v.bp; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d_bp_hold", k),
          {12'd0, out_valid, in_ready, out_ovf, 1'b0, fpu_op, d0, out_data} ,
          {12'd0, 1'b1, 1'b0, v.eo, 1'b0, 4'd0, v.ed, v.ed});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk($sformatf("v%0d_drop", k), {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_op"},   {28'd0, fpu_op},    32'd0);
    chk({tag, "_in12"}, {fpu_in1, fpu_in2}, 32'd0);
    chk({tag, "_ov"},   {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"}, {16'd0, out_data},  32'd0);
    chk({tag, "_oovf"}, {31'd0, out_ovf},   32'd0);
    chk({tag, "_cnt"},  {16'd0, out_cnt},   32'd0);
  endtask

  initial begin
    vecs[0] = '{1, 16'h3F80, 16'h4000, 16'h0, 16'h0, 0, 0,  16'h4000, 1'b0, 16'd1};
    vecs[1] = '{2, 16'h3F80, 16'h4000, 16'h4040, 16'h3F00, 0, 0, 16'h4060, 1'b0, 16'd2};
    vecs[2] = '{2, 16'h3F80, 16'h4000, 16'h4040, 16'h3F00, 3, 0, 16'h4060, 1'b0, 16'd2};
    vecs[3] = '{2, 16'h7F00, 16'h7F00, 16'h3F80, 16'h3F80, 0, 10, 16'h7F80, 1'b1, 16'd2};
    vecs[4] = '{1, 16'h4000, 16'h4000, 16'h0, 16'h0, 0, 0,  16'h4080, 1'b0, 16'd1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Build up partial state (acc, ovf, cnt), then reset mid-MUL.
    in_valid = 1'b1; in_a = 16'h7F00; in_b = 16'h7F00; in_last = 1'b0;
    @(negedge clk);                                    // MUL
    in_a = 16'h3F80; in_b = 16'h3F80; in_last = 1'b1;
    @(negedge clk);                                    // ADD, accepts pair 2
    @(negedge clk);                                    // MUL
    chk("pre_rst_op", {28'd0, fpu_op}, 32'h4);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; vector 0 proves partial sums were discarded.
    for (int k = 0; k < 5; k++) run_vec(k);

    // Back-to-back two-element sequence, cycle by cycle.
    chk("b2b_c0", {24'd0, in_ready, 3'd0, fpu_op}, {24'd0, 1'b1, 3'd0, 4'h0});
    in_valid = 1'b1; in_a = 16'h3F80; in_b = 16'h4000; in_last = 1'b0;
    @(negedge clk);
    chk("b2b_c1", {24'd0, in_ready, 3'd0, fpu_op}, {24'd0, 1'b0, 3'd0, 4'h4});
    in_a = 16'h4040; in_b = 16'h3F00; in_last = 1'b1;
    @(negedge clk);
    chk("b2b_c2", {in_ready, 3'd0, fpu_op, 8'd0, fpu_in2}, {1'b1, 3'd0, 4'h1, 8'd0, 16'h4000});
    @(negedge clk);
    chk("b2b_c3", {in_ready, 3'd0, fpu_op, fpu_in1[7:0], fpu_in2},
                  {1'b0, 3'd0, 4'h4, 8'h40, 16'h3F00});
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_c4", {in_ready, out_valid, 2'd0, fpu_op}, {1'b0, 1'b0, 2'd0, 4'h1});
    @(negedge clk);
    chk("b2b_done", {out_valid, out_ovf, fpu_op, 10'd0, out_data},
                    {1'b1, 1'b0, 4'h0, 10'd0, 16'h4060});
    chk("b2b_cnt", {16'd0, out_cnt}, 32'd2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_drop", {30'd0, out_valid, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/bf16_dot_seq.md
# bf16_dot_seq

Sequential bfloat16 dot-product issue stage placed directly upstream of the combinational `fpu`. Accepts a stream of operand pairs over a valid/ready handshake and drives the `fpu` op/operand inputs, first MUL (a×b), then ADD (acc+product). Captures `fpu` results into a running accumulator and emits the finished sum with a sticky overflow flag when the element tagged `last` completes. Time-shares one `fpu` instance, two `fpu` cycles per element.

## Interface
- `CNT_W`, 16, width of element counter `out_cnt_o`
- `clk_i  in  1  clock, all state on rising edge`
- `rst_ni  in  1  asynchronous, active-low reset`
- `in_valid_i  in  1  operand pair valid`
- `in_ready_o  out  1  stage can accept a pair this cycle`
- `in_a_i  in  16  bf16 operand a`
- `in_b_i  in  16  bf16 operand b`
- `in_last_i  in  1  pair is final element of the vector`
- `fpu_op_o  out  4  to fpu op_i: 4'b0100 MUL, 4'b0001 ADD, 4'b0000 idle`
- `fpu_in1_o  out  16  to fpu in1_i`
- `fpu_in2_o  out  16  to fpu in2_i`
- `fpu_out_i  in  16  from fpu out_o (combinational, same cycle)`
- `fpu_ovf_i  in  1  from fpu overflow_o`
- `out_valid_o  out  1  result valid`
- `out_ready_i  in  1  consumer accepts result`
- `out_data_o  out  16  bf16 dot product`
- `out_ovf_o  out  1  any MUL/ADD of this vector overflowed`
- `out_cnt_o  out  CNT_W  elements in this vector`

## Operation
- Registers: `a_q`, `b_q`, `last_q`, `prod_q`, `acc_q`, `ovf_q`, `cnt_q`, 2-bit state.
- States: IDLE, MUL, ADD, DONE.
- IDLE: `in_ready_o`=1; fpu outputs op=0000, in1=in2=0. On `in_valid_i`: latch a/b/last, `cnt_q`+=1, -> MUL.
- MUL: op=0100, in1=`a_q`, in2=`b_q`; `prod_q`<=`fpu_out_i`; `ovf_q`|=`fpu_ovf_i`; -> ADD.
- ADD: op=0001, in1=`acc_q`, in2=`prod_q`; `acc_q`<=`fpu_out_i`; `ovf_q`|=`fpu_ovf_i`.
  - `last_q`=1: -> DONE; `in_ready_o`=0.
  - `last_q`=0: `in_ready_o`=1; if `in_valid_i`, latch new pair, `cnt_q`+=1, -> MUL; else -> IDLE.
- DONE: `out_valid_o`=1, `out_data_o`=`acc_q`, `out_ovf_o`=`ovf_q`, `out_cnt_o`=`cnt_q`; fpu idle; `in_ready_o`=0. On `out_ready_i`: `acc_q`<=16'h0000, `ovf_q`<=0, `cnt_q`<=0, -> IDLE.
- Accumulator starts at +0 (16'h0000); first ADD yields the first product unchanged.
- `out_*` data held stable while `out_valid_o`=1 and `out_ready_i`=0.
- `cnt_q` wraps modulo 2^CNT_W; no error flag on wrap.
- Overflow does not abort: sequence continues with whatever `fpu_out_i` returns; flag is sticky to end of vector.
- A single-element vector (`in_last_i`=1 on first pair) is legal.

## Timing
- Reset (async assert, any state): state=IDLE, all registers 0; `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=0, `out_ovf_o`=0, `out_cnt_o`=0, `fpu_op_o`=0, `fpu_in1_o`=`fpu_in2_o`=0. Mid-vector partial sums discarded.
- Release is synchronous to `clk_i` by integration; first accept possible on first edge after deassert.
- All outputs are decoded from registers only (no combinational path from `in_*`/`out_ready_i` to outputs except none); `fpu_out_i` is sampled same cycle it is produced.
- Latency: pair accepted at edge E0 -> MUL cycle E0..E1 -> ADD cycle E1..E2 -> if last, `out_valid_o`=1 after E2 (3 edges accept-to-result).
- Throughput: one element per 2 cycles with back-to-back `in_valid_i`; 3 cycles if input gaps force IDLE.
- Result accepted at edge Ed; `in_ready_o`=1 in following cycle.

## Test plan
- Reset check: hold `rst_ni`=0 mid-MUL after one accepted pair -> all outputs at reset values immediately; after release, vector (16'h3F80×16'h4000, last) -> `out_data_o`=16'h4000, `out_cnt_o`=1.
- Two-element back-to-back: (3F80,4000),(4040,3F00,last) with `in_valid_i` held -> `in_ready_o` pattern 1,0,1,0; `fpu_op_o` sequence 0100,0001,0100,0001; `out_data_o`=16'h4060, `out_ovf_o`=0, `out_cnt_o`=2, valid 5 edges after first accept.
- Gapped input: same pairs with 3 idle cycles between -> identical result 16'h4060; state passes through IDLE.
- Overflow: (7F00,7F00),(3F80,3F80,last) -> `out_ovf_o`=1 sticky, `out_cnt_o`=2; next vector (4000,4000,last) -> 16'h4080, `out_ovf_o`=0.
- Backpressure: hold `out_ready_i`=0 for 10 cycles in DONE -> `out_*` stable, `in_ready_o`=0, fpu op=0000; release -> single handshake, accumulator cleared.
